// File: rtl/fd1p3_reg_bank.sv
// fd1p3_reg_bank: a bank of WIDTH independent enable flops with byte-lane write enables.
// Each bit is a preset-type or clear-type flop, chosen by its INIT_VAL bit.
// All bits share the clock, the asynchronous active-high reset, the global
// sample enable SP and the per-byte lane enables BE.
// Optional build macro FD1P3_UPD_FLAG_EN adds the registered load-done pulse upd_o.
// When the macro is undefined, the upd_o port and all of its logic are absent.
module fd1p3_reg_bank #(
    parameter int                WIDTH    = 32,
    parameter logic [255:0]      INIT_VAL = 256'b0,
    localparam int               NLANE    = (WIDTH + 7) / 8
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     D,
    input  logic                 SP,
    input  logic [NLANE-1:0]     BE,
    output logic [WIDTH-1:0]     Q
`ifdef FD1P3_UPD_FLAG_EN
    ,
    output logic                 upd_o
`endif
);

    // Only the low WIDTH bits of INIT_VAL are used.
    // A 1 bit makes that flop preset-type; a 0 bit makes it clear-type.
    localparam logic [WIDTH-1:0] INIT_W = INIT_VAL[WIDTH-1:0];

    generate
        if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
            $error("fd1p3_reg_bank: WIDTH must be in 1..256");
        end
    endgenerate

    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Expand byte-lane enables to a per-bit mask.
    // In the top lane, bits at or above WIDTH do not exist, so that lane is clipped naturally.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_mask[i] = BE[i / 8];
        end
    end

    // Next state: enabled bits take D, all other bits hold.
    // When SP is low, every bit holds regardless of BE.
    always_comb begin
        q_d = q_q;
        if (SP) begin
            q_d = (D & lane_mask) | (q_q & ~lane_mask);
        end
    end

    // Data register.
    // The asynchronous reset loads each bit's preset or clear value immediately.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            q_q <= INIT_W;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifdef FD1P3_UPD_FLAG_EN
    logic upd_d;
    logic upd_q;

    // A load occurs when sampling is enabled and at least one lane is enabled.
    always_comb begin
        upd_d = SP & (|BE);
    end

    // The load-done flag is registered alongside the data.
    // It stays high across back-to-back loads.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= upd_d;
        end
    end

    assign upd_o = upd_q;
`endif

endmodule

// File: tb/tb_fd1p3_reg_bank.sv
// Scoreboard bench for fd1p3_reg_bank: one 32-bit instance and one 12-bit instance (partial top lane).
// The stimulus process pushes hand-computed expectations into a queue.
// The monitor pops and compares them on the falling clock edge, or on a kick for asynchronous-reset checks.
module tb_fd1p3_reg_bank;

    typedef struct {
        int          due;
        int          dut;
        logic [31:0] q;
        logic        upd;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic        CK = 1'b0;
    int          cyc = 0;
    logic        kick = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        rst32, sp32;
    logic [3:0]  be32;
    logic [31:0] d32, q32;
    logic        rst12, sp12;
    logic [1:0]  be12;
    logic [11:0] d12, q12;
`ifdef FD1P3_UPD_FLAG_EN
    logic        upd32, upd12;
`endif

    fd1p3_reg_bank #(.WIDTH(32), .INIT_VAL(256'h8000_0001)) u32 (
        .CK(CK), .RST(rst32), .D(d32), .SP(sp32), .BE(be32), .Q(q32)
`ifdef FD1P3_UPD_FLAG_EN
        , .upd_o(upd32)
`endif
    );

    fd1p3_reg_bank #(.WIDTH(12), .INIT_VAL(256'hA5C)) u12 (
        .CK(CK), .RST(rst12), .D(d12), .SP(sp12), .BE(be12), .Q(q12)
`ifdef FD1P3_UPD_FLAG_EN
        , .upd_o(upd12)
`endif
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic push(input int dut, input int due, input logic [31:0] q,
                        input logic upd, input string name);
        exp_t e;
        e.dut = dut; e.due = due; e.q = q; e.upd = upd; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Monitor: compare every expectation that has come due
    initial begin
        exp_t        e;
        logic [31:0] got;
`ifdef FD1P3_UPD_FLAG_EN
        logic        gu;
`endif
        forever begin
            @(negedge CK or kick);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? q32 : {20'b0, q12};
                checks++;
                if (got !== e.q) begin
                    errors++;
                    $display("FAIL %s: Q got %h expected %h", e.name, got, e.q);
                end
`ifdef FD1P3_UPD_FLAG_EN
                gu = (e.dut == 0) ? upd32 : upd12;
                checks++;
                if (gu !== e.upd) begin
                    errors++;
                    $display("FAIL %s: upd_o got %b expected %b", e.name, gu, e.upd);
                end
`endif
            end
        end
    end

    // Stimulus
    initial begin
        rst32 = 1'b1; sp32 = 1'b0; be32 = 4'h0; d32 = 32'h0;
        rst12 = 1'b1; sp12 = 1'b0; be12 = 2'b00; d12 = 12'h0;
        #1;
        push(0, cyc, 32'h8000_0001, 1'b0, "rst32_init");
        push(1, cyc, 32'h0000_0A5C, 1'b0, "rst12_init");
        kick = ~kick;

        // Release reset and load zeros: the first edge after release must load
        rst32 = 1'b0; sp32 = 1'b1; be32 = 4'hF; d32 = 32'h0;
        push(0, cyc + 1, 32'h0000_0000, 1'b1, "load_zero");
        tick();

        // Asynchronous reset mid-cycle, checked before the next edge
        @(negedge CK);
        #1;
        rst32 = 1'b1; sp32 = 1'b0;
        #2;
        push(0, cyc, 32'h8000_0001, 1'b0, "async_rst32");
        kick = ~kick;

        // Loads are ignored while reset is held
        sp32 = 1'b1; be32 = 4'hF; d32 = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            push(0, cyc + 1, 32'h8000_0001, 1'b0, "rst_held");
            tick();
        end
        rst32 = 1'b0;
        push(0, cyc + 1, 32'hFFFF_FFFF, 1'b1, "first_after_release");
        tick();

        d32 = 32'hDEAD_BEEF;
        push(0, cyc + 1, 32'hDEAD_BEEF, 1'b1, "full_load");
        tick();

        be32 = 4'b0101; d32 = 32'h1122_3344;
        push(0, cyc + 1, 32'hDE22_BE44, 1'b1, "lanes_0_2");
        tick();

        sp32 = 1'b0; be32 = 4'hF; d32 = 32'h0000_0000;
        push(0, cyc + 1, 32'hDE22_BE44, 1'b0, "sp_low_hold");
        tick();

        sp32 = 1'b1; be32 = 4'h0; d32 = 32'h5555_5555;
        push(0, cyc + 1, 32'hDE22_BE44, 1'b0, "be_zero_hold");
        tick();

        be32 = 4'b1000; d32 = 32'h1200_0000;
        push(0, cyc + 1, 32'h1222_BE44, 1'b1, "lane3");
        tick();

        be32 = 4'b0010; d32 = 32'h0000_AB00;
        push(0, cyc + 1, 32'h1222_AB44, 1'b1, "lane1_back_to_back");
        tick();

        sp32 = 1'b0;
        push(0, cyc + 1, 32'h1222_AB44, 1'b0, "idle32");
        tick();

        // 12-bit bank with a partial top lane
        rst12 = 1'b0; sp12 = 1'b1; be12 = 2'b10; d12 = 12'h3FF;
        push(1, cyc + 1, 32'h0000_035C, 1'b1, "w12_top_lane");
        tick();

        be12 = 2'b01; d12 = 12'h0A7;
        push(1, cyc + 1, 32'h0000_03A7, 1'b1, "w12_low_lane");
        tick();

        be12 = 2'b11; d12 = 12'hFFF;
        push(1, cyc + 1, 32'h0000_0FFF, 1'b1, "w12_both");
        tick();

        sp12 = 1'b0;
        push(1, cyc + 1, 32'h0000_0FFF, 1'b0, "w12_hold");
        tick();

        @(negedge CK);
        #1;
        rst12 = 1'b1;
        #2;
        push(1, cyc, 32'h0000_0A5C, 1'b0, "async_rst12");
        kick = ~kick;
        tick();

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fd1p3_reg_bank.md
FD1P3_REG_BANK -- requirements
Module: fd1p3_reg_bank

Interface
- REQ-001 Parameter WIDTH, default 32: number of register bits; legal range 1..256.
- REQ-002 Parameter INIT_VAL, default 32'b0: per-bit reset/power-up value.
  - Bit i = 1 gives preset behaviour (FD1P3BX style).
  - Bit i = 0 gives clear behaviour (FD1P3DX style).
  - Only bits [WIDTH-1:0] are used.
- REQ-003 Derived constant NLANE = ceil(WIDTH/8): number of byte lanes.
- REQ-004 One clock; reset is asynchronous and active-high.
- REQ-005 Ports, clock and reset first:
  - CK  input  1  clock; rising-edge active.
  - RST  input  1  asynchronous active-high reset.
  - D  input  WIDTH  data in.
  - SP  input  1  global clock enable (sample enable).
  - BE  input  NLANE  byte-lane enables; lane k covers bits [8k+7:8k], clipped to WIDTH-1.
  - Q  output  WIDTH  registered data out.
  - upd_o  output  1  load-done pulse; present only per REQ-016.

Function
- REQ-006 Load: at a CK rising edge with RST low and SP high, Q[i] SHALL take D[i] for every bit i in a lane whose BE bit is 1.
- REQ-007 Hold:
  - Bits in lanes with BE = 0 SHALL hold.
  - All bits SHALL hold when SP is low, regardless of BE.
- REQ-008 Latency: Q SHALL reflect the loaded D after the same rising edge, one cycle after D/SP/BE are sampled; no combinational path from D to Q.
- REQ-009 Partial last lane: when WIDTH is not a multiple of 8, the top lane SHALL cover only bits [WIDTH-1:8(NLANE-1)]; nonexistent bits SHALL be ignored.
- REQ-010 Each bit SHALL behave as an independent enable flop.
  - No bit SHALL depend on any other bit except through the shared SP, BE and RST.
  - The bit's INIT_VAL bit selects between preset and clear type.

Reset
- REQ-011 When RST is high, asynchronously and without waiting for CK: Q SHALL equal INIT_VAL[WIDTH-1:0] and upd_o SHALL be 0.
- REQ-012 While RST is high, clock edges, SP, BE and D SHALL have no effect.
- REQ-013 RST has priority over SP in the same cycle.
- REQ-014 Reset release:
  - The first CK rising edge after RST falls SHALL operate normally (load if SP and BE).
  - No extra dead cycle.
- REQ-015 Power-up initial value (FPGA configuration) SHALL be Q = INIT_VAL and upd_o = 0.

Configuration
- REQ-016 Macro FD1P3_UPD_FLAG_EN.
  - Defined: upd_o SHALL be a registered pulse, high for exactly one cycle after every edge where RST = 0, SP = 1 and |BE = 1; it stays high on consecutive loading cycles.
  - Undefined: the upd_o port SHALL not exist and no related logic SHALL be built; Q behaviour is identical in both builds.

Verification
- REQ-017 WIDTH=32, INIT_VAL=32'h8000_0001: pulse RST high mid-cycle -> Q = 32'h8000_0001 immediately, before the next CK edge, even if Q was 32'h0000_0000.
- REQ-018 RST=0, SP=1, BE=4'hF, D=32'hDEAD_BEEF -> after one edge Q = 32'hDEAD_BEEF; upd_o = 1 for one cycle (macro defined).
- REQ-019 Starting from Q=32'hDEAD_BEEF, SP=1, BE=4'b0101, D=32'h1122_3344 -> Q = 32'hDE22_BE44; with SP=0 and any BE/D -> Q unchanged and upd_o = 0.
- REQ-020 RST held high, SP=1, BE=4'hF, D=32'hFFFF_FFFF for 3 edges -> Q stays 32'h8000_0001; RST falls -> Q = 32'hFFFF_FFFF on the first following edge.
- REQ-021 WIDTH=12, INIT_VAL=12'hA5C, BE=2'b10, D=12'h3FF -> Q = 12'h35C; after RST -> Q = 12'hA5C.
- REQ-022 Build without FD1P3_UPD_FLAG_EN -> compiles without upd_o; REQ-017..REQ-021 Q results are unchanged.
